rot_sel: RTL and testbench

- Registered front-panel rotary register selector; successor to the purely combinational rotary decode.
- Accepts raw step-up/step-down contacts and a direct position load.
- Synchronises and debounces the contacts, keeps the current rotary position with wrap-around, and drives the registered 11-bit rotary bus select to the panel display/bus logic.
- Generalised through debounce, reset-position and auto-repeat parameters.

---
 rtl/rot_pkg.sv | 59 +++++
 rtl/rot_deb.sv | 79 +++++++
 rtl/rot_sel.sv | 74 +++++++
 tb/tb_rot_sel.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared position and bus-select encodings for the rotary selector.
// The optional auto-repeat feature is enabled with ROT_AUTOREPEAT_EN.
package rot_pkg;

  localparam logic [3:0] ROT_POS_R0  = 4'd0;
  localparam logic [3:0] ROT_POS_R1  = 4'd1;
  localparam logic [3:0] ROT_POS_R2  = 4'd2;
  localparam logic [3:0] ROT_POS_R3  = 4'd3;
  localparam logic [3:0] ROT_POS_R4  = 4'd4;
  localparam logic [3:0] ROT_POS_R5  = 4'd5;
  localparam logic [3:0] ROT_POS_R6  = 4'd6;
  localparam logic [3:0] ROT_POS_R7  = 4'd7;
  localparam logic [3:0] ROT_POS_IC  = 4'd8;
  localparam logic [3:0] ROT_POS_AC  = 4'd9;
  localparam logic [3:0] ROT_POS_AR  = 4'd10;
  localparam logic [3:0] ROT_POS_IR  = 4'd11;
  localparam logic [3:0] ROT_POS_SR  = 4'd12;
  localparam logic [3:0] ROT_POS_RZ  = 4'd13;
  localparam logic [3:0] ROT_POS_KB  = 4'd14;
  localparam logic [3:0] ROT_POS_MAX = 4'd14;

  localparam logic [10:0] ROT_BUS_R0 = 11'b10000000000;
  localparam logic [10:0] ROT_BUS_R1 = 11'b10010000000;
  localparam logic [10:0] ROT_BUS_R2 = 11'b10100000000;
  localparam logic [10:0] ROT_BUS_R3 = 11'b10110000000;
  localparam logic [10:0] ROT_BUS_R4 = 11'b11000000000;
  localparam logic [10:0] ROT_BUS_R5 = 11'b11010000000;
  localparam logic [10:0] ROT_BUS_R6 = 11'b11100000000;
  localparam logic [10:0] ROT_BUS_R7 = 11'b11110000000;
  localparam logic [10:0] ROT_BUS_IC = 11'b00001000000;
  localparam logic [10:0] ROT_BUS_AC = 11'b00000100000;
  localparam logic [10:0] ROT_BUS_AR = 11'b00000010000;
  localparam logic [10:0] ROT_BUS_IR = 11'b00000001000;
  localparam logic [10:0] ROT_BUS_SR = 11'b00000000100;
  localparam logic [10:0] ROT_BUS_RZ = 11'b00000000010;
  localparam logic [10:0] ROT_BUS_KB = 11'b00000000001;

  function automatic logic [10:0] rot_code(input logic [3:0] p);
    case (p)
      ROT_POS_R0: return ROT_BUS_R0;
      ROT_POS_R1: return ROT_BUS_R1;
      ROT_POS_R2: return ROT_BUS_R2;
      ROT_POS_R3: return ROT_BUS_R3;
      ROT_POS_R4: return ROT_BUS_R4;
      ROT_POS_R5: return ROT_BUS_R5;
      ROT_POS_R6: return ROT_BUS_R6;
      ROT_POS_R7: return ROT_BUS_R7;
      ROT_POS_IC: return ROT_BUS_IC;
      ROT_POS_AC: return ROT_BUS_AC;
      ROT_POS_AR: return ROT_BUS_AR;
      ROT_POS_IR: return ROT_BUS_IR;
      ROT_POS_SR: return ROT_BUS_SR;
      ROT_POS_RZ: return ROT_BUS_RZ;
      ROT_POS_KB: return ROT_BUS_KB;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/rot_deb.sv
// Contact conditioner: 2-FF synchroniser, debounce, rising-edge step pulse,
// and (with ROT_AUTOREPEAT_EN) hold-to-repeat step generation.
module rot_deb
  import rot_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int REP_DELAY  = 4096,
  parameter int REP_PERIOD = 1024
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic raw,
  input  logic clr,
  output logic step
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1, sync2, deb;
  logic [CW-1:0] cnt;
  logic          differ, flip, rep_fire;

  assign differ = (sync2 != deb);
  assign flip   = differ && (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values and the synchroniser chain really is two stages.
      sync1 <= raw;
      sync2 <= sync1;
      if (flip) begin
        deb <= sync2;
        cnt <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      step <= (flip && sync2) || rep_fire;
    end
  end

`ifdef ROT_AUTOREPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rep_cnt;
  logic          rep_on;

  // flip while deb is high is the debounced fall, which must not repeat
  assign rep_fire = deb && !flip && !clr &&
                    (rep_on ? (rep_cnt == RW'(REP_PERIOD - 1))
                            : (rep_cnt == RW'(REP_DELAY - 1)));

  always_ff @(posedge clk_sys) begin
    if (rst || clr || !deb || flip) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt <= '0;
      rep_on  <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign rep_fire   = 1'b0;
`endif

endmodule

// File: rtl/rot_sel.sv
// Registered rotary register selector with debounced step contacts and load.
// Define ROT_AUTOREPEAT_EN to add hold-to-repeat stepping.
module rot_sel
  import rot_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int RESET_POS  = 0,
  parameter int REP_DELAY  = 4096,
  parameter int REP_PERIOD = 1024
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        step_up,
  input  logic        step_dn,
  input  logic        load,
  input  logic [3:0]  load_pos,
  output logic [3:0]  pos,
  output logic [10:0] rot_bus,
  output logic        changed
);

  logic       up_ev, dn_ev;
  logic [3:0] nxt;

  rot_deb #(
    .DEB_CYCLES(DEB_CYCLES),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD)
  ) u_deb_up (
    .clk_sys(clk_sys),
    .rst    (rst),
    .raw    (step_up),
    .clr    (load),
    .step   (up_ev)
  );

  rot_deb #(
    .DEB_CYCLES(DEB_CYCLES),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD)
  ) u_deb_dn (
    .clk_sys(clk_sys),
    .rst    (rst),
    .raw    (step_dn),
    .clr    (load),
    .step   (dn_ev)
  );

  always_comb begin
    // NOTE: nxt gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    nxt = pos;
    if (load) begin
      nxt = (load_pos > ROT_POS_MAX) ? ROT_POS_MAX : load_pos;
    end else if (up_ev && !dn_ev) begin
      nxt = (pos == ROT_POS_MAX) ? ROT_POS_R0 : pos + 4'd1;
    end else if (dn_ev && !up_ev) begin
      nxt = (pos == ROT_POS_R0) ? ROT_POS_MAX : pos - 4'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pos     <= 4'(RESET_POS);
      rot_bus <= rot_code(4'(RESET_POS));
      changed <= 1'b0;
    end else begin
      pos     <= nxt;
      rot_bus <= rot_code(nxt);
      changed <= (nxt != pos);
    end
  end

endmodule

// File: tb/tb_rot_sel.sv
// Scoreboard bench for rot_sel; default build exercises debounce, wrap, load
// and cancel; with ROT_AUTOREPEAT_EN it exercises the auto-repeat sequence.
module tb_rot_sel;

`ifdef ROT_AUTOREPEAT_EN
  localparam int DEB = 2;
`else
  localparam int DEB = 4;
`endif
  localparam int RDLY = 8;
  localparam int RPER = 4;

  typedef struct {
    logic [3:0]  pos;
    logic [10:0] bus;
    int          cyc;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        step_up = 1'b0, step_dn = 1'b0, load = 1'b0;
  logic [3:0]  load_pos = 4'd0;
  logic [3:0]  pos, pos9;
  logic [10:0] rot_bus, rot_bus9;
  logic        changed, changed9;

  int   cyc = 0;
  int   total = 0;
  int   fails = 0;
  exp_t sbq[$];
  exp_t e;

  rot_sel #(.DEB_CYCLES(DEB), .RESET_POS(0), .REP_DELAY(RDLY), .REP_PERIOD(RPER)) dut (
    .clk_sys(clk_sys), .rst(rst), .step_up(step_up), .step_dn(step_dn),
    .load(load), .load_pos(load_pos), .pos(pos), .rot_bus(rot_bus), .changed(changed)
  );

  rot_sel #(.DEB_CYCLES(DEB), .RESET_POS(9), .REP_DELAY(RDLY), .REP_PERIOD(RPER)) dut9 (
    .clk_sys(clk_sys), .rst(rst), .step_up(step_up), .step_dn(step_dn),
    .load(load), .load_pos(load_pos), .pos(pos9), .rot_bus(rot_bus9), .changed(changed9)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_chg(input logic [3:0] p, input logic [10:0] b, input int c);
    exp_t x;
    x.pos = p;
    x.bus = b;
    x.cyc = c;
    sbq.push_back(x);
  endtask

  task automatic press(input logic up, input logic dn);
    step_up = up;
    step_dn = dn;
    tick(DEB + 6);
    step_up = 1'b0;
    step_dn = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_pos = v;
    tick(1);
    load = 1'b0;
    tick(2);
  endtask

  // Monitor: every changed pulse must match the oldest expected update.
  always @(negedge clk_sys) begin
    if (!rst && changed) begin
      if (sbq.size() == 0) begin
        total++;
        fails++;
        $display("FAIL unexpected_change: pos %0d bus %b at cycle %0d, expected no change",
                 pos, rot_bus, cyc);
      end else begin
        e = sbq.pop_front();
        check("sb_pos", 32'(pos), 32'(e.pos));
        check("sb_bus", 32'(rot_bus), 32'(e.bus));
        if (e.cyc >= 0) check("sb_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    tick(3);
    check("rst_pos0", 32'(pos), 32'd0);
    check("rst_bus0", 32'(rot_bus), 32'(11'b10000000000));
    check("rst_chg0", 32'(changed), 32'd0);
    check("rst_pos9", 32'(pos9), 32'd9);
    check("rst_bus9", 32'(rot_bus9), 32'(11'b00000100000));
    check("rst_chg9", 32'(changed9), 32'd0);
    rst = 1'b0;
    tick(2);

`ifdef ROT_AUTOREPEAT_EN
    expect_chg(4'd13, 11'b00000000010, -1);
    do_load(4'd13);
    tick(3);
    // Raw rises before edge T = cyc+1: debounced rise at T+3, first step at T+4,
    // repeat steps land 8, 12, 16, 20 cycles after that.
    expect_chg(4'd14, 11'b00000000001, cyc + 5);
    expect_chg(4'd0,  11'b10000000000, cyc + 13);
    expect_chg(4'd1,  11'b10010000000, cyc + 17);
    expect_chg(4'd2,  11'b10100000000, cyc + 21);
    expect_chg(4'd3,  11'b10110000000, cyc + 25);
    step_up = 1'b1;
    tick(22);
    step_up = 1'b0;
    tick(20);
    check("hold_pos", 32'(pos), 32'd3);
`else
    // Latency: raw rises before edge T = cyc+1, pos updates at edge T+6.
    expect_chg(4'd1, 11'b10010000000, cyc + 7);
    press(1'b1, 1'b0);

    // 3-cycle glitch never completes the debounce.
    step_up = 1'b1;
    tick(3);
    step_up = 1'b0;
    tick(12);
    check("glitch_pos", 32'(pos), 32'd1);

    // Bounce 1,1,0,1,1,1,1 then held: one step only.
    expect_chg(4'd2, 11'b10100000000, -1);
    for (int i = 0; i < 7; i++) begin
      step_up = (i != 2);
      tick(1);
    end
    tick(6);
    step_up = 1'b0;
    tick(12);

    // Wrap in both directions.
    expect_chg(4'd0, 11'b10000000000, -1);
    do_load(4'd0);
    expect_chg(4'd14, 11'b00000000001, -1);
    press(1'b0, 1'b1);
    expect_chg(4'd0, 11'b10000000000, -1);
    press(1'b1, 1'b0);

    // Load clamps 15 to KB.
    expect_chg(4'd14, 11'b00000000001, -1);
    do_load(4'd15);

    // Load coinciding with an up event wins; reload of the same value is silent.
    expect_chg(4'd5, 11'b11010000000, -1);
    step_up = 1'b1;
    tick(6);
    load     = 1'b1;
    load_pos = 4'd5;
    tick(1);
    load = 1'b0;
    tick(2);
    do_load(4'd5);
    step_up = 1'b0;
    tick(12);
    check("load_win_pos", 32'(pos), 32'd5);

    // Simultaneous up and down cancel.
    press(1'b1, 1'b1);
    check("cancel_pos", 32'(pos), 32'd5);

    // Non-register codes.
    expect_chg(4'd4, 11'b11000000000, -1);
    press(1'b0, 1'b1);
    expect_chg(4'd8, 11'b00001000000, -1);
    do_load(4'd8);
    expect_chg(4'd9, 11'b00000100000, -1);
    press(1'b1, 1'b0);
    expect_chg(4'd12, 11'b00000000100, -1);
    do_load(4'd12);
    expect_chg(4'd11, 11'b00000001000, -1);
    press(1'b0, 1'b1);
    expect_chg(4'd10, 11'b00000010000, -1);
    press(1'b0, 1'b1);
`endif

    for (int i = 0; i < 50 && sbq.size() != 0; i++) tick(1);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
